// File: rtl/frame_streamer.sv
// Host-side initiator for the serial pixel-stream filter protocol.
// Holds one source frame, streams it in raster order, pulses enable_process after a guard gap,
// then captures the returned W*D pixels into a host-readable result RAM.
module frame_streamer #(
  parameter int unsigned WIDTH       = 410,
  parameter int unsigned DEPTH       = 361,
  parameter int unsigned COLOR_DEPTH = 8,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned TIMEOUT     = 2**24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_we_i,
  input  logic [ADDR_W-1:0]      ld_addr_i,
  input  logic [COLOR_DEPTH-1:0] ld_data_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  input  logic [ADDR_W-1:0]      rd_addr_i,
  output logic [COLOR_DEPTH-1:0] rd_data_o,
  output logic                   enable_o,
  output logic [COLOR_DEPTH-1:0] image_input_o,
  output logic                   enable_process_o,
  input  logic                   finish_i,
  input  logic [COLOR_DEPTH-1:0] image_output_i
);

  localparam int unsigned N    = WIDTH * DEPTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW   = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W:0]   NExt  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LastK = ADDR_W'(N - 1);
  localparam logic [GW-1:0]     LastG = GW'(GUARD - 1);
  localparam logic [TW-1:0]     LastT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StKick, StStream, StGuard, StProc, StWaitF, StCapt, StDone
  } state_e;

  state_e                 state_q;
  logic [ADDR_W-1:0]      k_q;
  logic [GW-1:0]          g_q;
  logic [TW-1:0]          t_q;
  logic                   busy_q, done_q, error_q, enable_q, enable_process_q;
  logic [COLOR_DEPTH-1:0] image_input_q;
  logic [COLOR_DEPTH-1:0] rd_data_q;

  logic [COLOR_DEPTH-1:0] src_mem [N];
  logic [COLOR_DEPTH-1:0] res_mem [N];
  logic [COLOR_DEPTH-1:0] src_rd_q;
  logic [ADDR_W-1:0]      src_raddr;
  logic                   ld_ok, rd_ok;

  assign ld_ok = ld_we_i && !busy_q && ({1'b0, ld_addr_i} < NExt);
  assign rd_ok = {1'b0, rd_addr_i} < NExt;

  // Source read runs one pixel ahead of image_input: addr 0 is read on the start edge,
  // so a same-cycle write to addr 0 is not seen by this transfer.
  always_comb begin
    src_raddr = '0;
    if (state_q == StKick) begin
      src_raddr = ADDR_W'(1);
    end else if (state_q == StStream) begin
      src_raddr = k_q + ADDR_W'(2);
    end
    if ({1'b0, src_raddr} >= NExt) begin
      src_raddr = '0;
    end
  end

  // Source frame RAM: host writes only while idle, synchronous read.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      src_mem[ld_addr_i[IdxW-1:0]] <= ld_data_i;
    end
    src_rd_q <= src_mem[src_raddr[IdxW-1:0]];
  end

  // Result RAM capture port.
  always_ff @(posedge clk) begin
    if (state_q == StCapt) begin
      res_mem[k_q[IdxW-1:0]] <= image_output_i;
    end
  end

  // Result RAM host read port, registered every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_ok ? res_mem[rd_addr_i[IdxW-1:0]] : '0;
    end
  end

  // Transfer sequencer with registered protocol outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      k_q              <= '0;
      g_q              <= '0;
      t_q              <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      enable_q         <= 1'b0;
      enable_process_q <= 1'b0;
      image_input_q    <= '0;
    end else begin
      enable_q         <= 1'b0;
      enable_process_q <= 1'b0;
      done_q           <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StKick;
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
            enable_q <= 1'b1;
          end
        end
        StKick: begin
          state_q       <= StStream;
          k_q           <= '0;
          image_input_q <= src_rd_q;
        end
        StStream: begin
          if (k_q == LastK) begin
            state_q       <= StGuard;
            k_q           <= '0;
            g_q           <= '0;
            image_input_q <= '0;
          end else begin
            k_q           <= k_q + 1'b1;
            image_input_q <= src_rd_q;
          end
        end
        StGuard: begin
          if (g_q == LastG) begin
            state_q          <= StProc;
            enable_process_q <= 1'b1;
          end else begin
            g_q <= g_q + 1'b1;
          end
        end
        StProc: begin
          state_q <= StWaitF;
          t_q     <= '0;
        end
        StWaitF: begin
          if (finish_i) begin
            state_q <= StCapt;
            k_q     <= '0;
          end else if (t_q == LastT) begin
            state_q <= StDone;
            error_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        // Runs the full N samples even if finish drops early.
        StCapt: begin
          if (k_q == LastK) begin
            state_q <= StDone;
            k_q     <= '0;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign enable_o         = enable_q;
  assign enable_process_o = enable_process_q;
  assign image_input_o    = image_input_q;
  assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer with a small frame (4x3) and a behavioural filter responder.
module tb_frame_streamer;

  localparam int N = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_we = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       enable, enable_process;
  logic [7:0] image_input;
  logic       finish = 1'b0;
  logic [7:0] image_output = '0;

  frame_streamer #(
    .WIDTH(4), .DEPTH(3), .COLOR_DEPTH(8), .ADDR_W(4), .GUARD(4), .TIMEOUT(64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ld_we_i          (ld_we),
    .ld_addr_i        (ld_addr),
    .ld_data_i        (ld_data),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .rd_addr_i        (rd_addr),
    .rd_data_o        (rd_data),
    .enable_o         (enable),
    .image_input_o    (image_input),
    .enable_process_o (enable_process),
    .finish_i         (finish),
    .image_output_i   (image_output)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle trace of one transfer; cycle 0 is the cycle after start is accepted.
  logic       tr_en   [256];
  logic       tr_ep   [256];
  logic       tr_busy [256];
  logic       tr_done [256];
  logic       tr_err  [256];
  logic [7:0] tr_img  [256];
  int en_cnt, ep_cnt, done_cnt, done_cyc;

  typedef struct {
    int       cyc;
    bit       en;
    bit       ep;
    bit       busy;
    bit       done;
    int       img;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int data);
    ld_we   = 1'b1;
    ld_addr = 4'(addr);
    ld_data = 8'(data);
    tick();
    ld_we   = 1'b0;
  endtask

  // mode 0: finish 7 cycles after enable_process, held for the whole stream
  // mode 1: finish never rises; mode 2: finish drops after 3 cycles
  task automatic run_xfer(input int mode, input int base, input bit pre_we, input int pre_addr,
                          input int pre_data, input bit inject);
    int ep_c;
    int f0;
    start = 1'b1;
    if (pre_we) begin
      ld_we   = 1'b1;
      ld_addr = 4'(pre_addr);
      ld_data = 8'(pre_data);
    end
    tick();
    start    = 1'b0;
    ld_we    = 1'b0;
    en_cnt   = 0;
    ep_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1;
    ep_c     = -1;
    for (int c = 0; c < 200; c++) begin
      tr_en[c]   = enable;
      tr_ep[c]   = enable_process;
      tr_busy[c] = busy;
      tr_done[c] = done;
      tr_err[c]  = error;
      tr_img[c]  = image_input;
      if (enable) en_cnt++;
      if (enable_process) begin
        ep_cnt++;
        ep_c = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      finish       = 1'b0;
      image_output = 8'h55;
      if (mode != 1 && ep_c >= 0) begin
        f0 = ep_c + 7;
        if (c >= f0 && c <= f0 + N && (mode == 0 || c <= f0 + 2)) finish = 1'b1;
        if (c >= f0 + 1 && c <= f0 + N) image_output = 8'(base + c - f0 - 1);
      end
      if (inject && c == 5) begin
        ld_we   = 1'b1;
        ld_addr = 4'd5;
        ld_data = 8'hEE;
        start   = 1'b1;
      end else if (inject && c == 6) begin
        ld_we = 1'b0;
        start = 1'b0;
      end
      tick();
    end
    finish = 1'b0;
    start  = 1'b0;
    ld_we  = 1'b0;
    chk("done_seen", done_cnt, 1);
  endtask

  task automatic check_res(input int base, input string tag);
    for (int k = 0; k < N; k++) begin
      rd_addr = 4'(k);
      tick();
      chk($sformatf("%s res[%0d]", tag, k), int'(rd_data), (base + k) & 255);
    end
  endtask

  initial begin
    // expected trace of a full responder transfer with src[k]=k+1
    vecs.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    for (int k = 1; k <= 12; k++) vecs.push_back('{k, 1'b0, 1'b0, 1'b1, 1'b0, k});
    for (int k = 13; k <= 16; k++) vecs.push_back('{k, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{17, 1'b0, 1'b1, 1'b1, 1'b0, 0});
    vecs.push_back('{18, 1'b0, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{37, 1'b0, 1'b0, 1'b1, 1'b1, 0});
    vecs.push_back('{38, 1'b0, 1'b0, 1'b0, 1'b0, 0});

    // reset state
    #12;
    chk("reset outs", int'({busy, done, error, enable, enable_process}), 0);
    chk("reset image_input", int'(image_input), 0);
    chk("reset rd_data", int'(rd_data), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < N; k++) load(k, k + 1);

    // reset mid-stream aborts at once
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre-reset image_input", int'(image_input), 5);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort enable", int'(enable), 0);
    chk("abort image_input", int'(image_input), 0);
    tick();
    rst = 1'b0;
    tick();

    // full transfer with responder, trace checked against table
    run_xfer(0, 200, 1'b0, 0, 0, 1'b0);
    foreach (vecs[i]) begin
      chk($sformatf("trace c=%0d", vecs[i].cyc),
          int'({tr_en[vecs[i].cyc], tr_ep[vecs[i].cyc], tr_busy[vecs[i].cyc],
                tr_done[vecs[i].cyc], tr_img[vecs[i].cyc]}),
          int'({vecs[i].en, vecs[i].ep, vecs[i].busy, vecs[i].done, 8'(vecs[i].img)}));
    end
    chk("enable count", en_cnt, 1);
    chk("enable_process count", ep_cnt, 1);
    check_res(200, "resp");

    // finish drops early: capture still takes N samples
    run_xfer(2, 50, 1'b0, 0, 0, 1'b0);
    chk("early-drop done cycle", done_cyc, 37);
    check_res(50, "early");

    // finish never rises
    run_xfer(1, 0, 1'b0, 0, 0, 1'b0);
    chk("timeout done cycle", done_cyc, 82);
    chk("timeout error at done", int'(tr_err[82]), 1);
    chk("timeout error after", int'(error), 1);
    chk("timeout busy after", int'(busy), 0);

    // accepted start clears error; same-cycle write to addr 0 misses this frame
    run_xfer(0, 10, 1'b1, 0, 8'h77, 1'b0);
    chk("error cleared", int'(tr_err[0]), 0);
    chk("addr0 same-cycle old", int'(tr_img[1]), 1);

    // same-cycle write to addr 3 lands in frame; writes/start while busy dropped
    run_xfer(0, 30, 1'b1, 3, 8'h33, 1'b1);
    chk("addr3 same-cycle new", int'(tr_img[4]), 8'h33);
    chk("busy start no enable", en_cnt, 1);
    chk("busy start done count", done_cnt, 1);

    run_xfer(0, 90, 1'b0, 0, 0, 1'b0);
    chk("src[0] now written", int'(tr_img[1]), 8'h77);
    chk("src[3] kept", int'(tr_img[4]), 8'h33);
    chk("src[5] unchanged", int'(tr_img[6]), 6);
    check_res(90, "last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
